// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// controller states and the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shift-add or restoring-divide step per cycle, WIDTH steps per operation.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic signed [WIDTH-1:0] sign_fix(
    input logic signed [WIDTH-1:0] v,
    input logic                    neg
  );
    return neg ? -v : v;
  endfunction

  function automatic logic signed [2*WIDTH-1:0] sign_fix_2w(
    input logic signed [2*WIDTH-1:0] v,
    input logic                      neg
  );
    return neg ? -v : v;
  endfunction

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] opd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shq;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] shq_nxt;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             last_step;

  assign signed_op = ~op[0];
  assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // acc holds the running high word (product) or partial remainder (divide);
  // shq holds the multiplier being consumed or the dividend/quotient shifter.
  always_comb begin
    mul_sum   = {1'b0, acc} + (shq[0] ? {1'b0, opd} : '0);
    div_shift = {acc, shq[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd};
    acc_nxt   = acc;
    shq_nxt   = shq;
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        acc_nxt = div_diff[WIDTH-1:0];
        shq_nxt = {shq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = div_shift[WIDTH-1:0];
        shq_nxt = {shq[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = mul_sum[WIDTH:1];
      shq_nxt = {mul_sum[0], shq[WIDTH-1:1]};
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (is_div) begin
      res_hi = sign_fix(acc_nxt, neg_rem);
      res_lo = sign_fix(shq_nxt, neg_res);
    end else begin
      {res_hi, res_lo} = sign_fix_2w({acc_nxt, shq_nxt}, neg_res);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opd     <= '0;
      acc     <= '0;
      shq     <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= CALC;
            busy    <= 1'b1;
            cnt     <= '0;
            is_div  <= op[1];
            acc     <= '0;
            // Divide by zero keeps the all-ones quotient positive.
            neg_res <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]) && !(op[1] && b == '0);
            neg_rem <= signed_op && a[WIDTH-1];
            if (op[1]) begin
              shq <= abs_a;
              opd <= abs_b;
            end else begin
              opd <= abs_a;
              shq <= abs_b;
            end
          end else begin
            if (hilo_we[1]) hi <= wdata;
            if (hilo_we[0]) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          shq <= shq_nxt;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= DONE;
            done  <= 1'b1;
            cnt   <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, handshake, HI/LO writes,
// signed/unsigned multiply and divide corner cases, mid-operation reset.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  hilo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts one operation and follows it to completion. With disturb set,
  // start/hilo_we are also driven alongside the start and mid-CALC.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi,
                        input logic [31:0] elo, input bit disturb);
    logic [31:0] hi0, lo0;
    int n, busy_low, done_cnt;
    @(negedge clk);
    hi0 = hi;
    lo0 = lo;
    op = o; a = x; b = y; start = 1'b1;
    if (disturb) begin
      hilo_we = 2'b11;
      wdata   = 32'hDEAD_BEEF;
    end
    @(posedge clk); #1;
    start = 1'b0; hilo_we = 2'b00;
    check({tag, "_busy_t0"}, 64'(busy), 64'd1);
    n = 0; busy_low = 0; done_cnt = 0;
    while (!done && n < 40) begin
      if (disturb && n == 3) begin
        start = 1'b1; hilo_we = 2'b01; wdata = 32'h1111_2222;
        op = OP_MULTU; a = 32'h3; b = 32'h3;
      end
      if (disturb && n == 6) begin
        start = 1'b0; hilo_we = 2'b00;
      end
      if (n == 10) begin
        check({tag, "_hi_hold"}, 64'(hi), 64'(hi0));
        check({tag, "_lo_hold"}, 64'(lo), 64'(lo0));
      end
      @(posedge clk); #1;
      n++;
      if (!busy) busy_low++;
    end
    start = 1'b0; hilo_we = 2'b00;
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_busy_calc"}, 64'(busy_low), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    @(posedge clk); #1;
    check({tag, "_done_once"}, 64'(done), 64'd0);
    check({tag, "_busy_t33"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = OP_MULT; a = '0; b = '0;
    hilo_we = 2'b00; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    rst = 1'b1;

    // MTHI/MTLO in IDLE
    @(negedge clk);
    hilo_we = 2'b11; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hilo_we = 2'b00;
    check("mt_both_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mt_both_lo", 64'(lo), 64'hA5A5_A5A5);
    @(negedge clk);
    hilo_we = 2'b10; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    hilo_we = 2'b00;
    check("mthi_hi", 64'(hi), 64'h0000_1234);
    check("mthi_lo", 64'(lo), 64'hA5A5_A5A5);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("divu",      OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0);
    run_op("div_nega",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_negb",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_zero", OP_DIVU,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div_zero",  OP_DIV,   32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_dist", OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b1);

    // Reset in the middle of an operation
    @(negedge clk);
    hilo_we = 2'b11; wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    hilo_we = 2'b00; op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("multu_post", OP_MULTU, 32'd5, 32'd6, 32'h0000_0000, 32'h0000_001E, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
